// File: rtl/serial_pattern_generator.sv
// Serial pattern generator: shifts a latched pattern out MSB-first with an optional
// repeat count and zero-filled gap cycles between repetitions. All outputs are registered.
module serial_pattern_generator #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             data,
    output logic             valid,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;
    logic [LEN_W-1:0] bit_idx;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             len_ok;

    // Pattern bit selected through a shift so the index width need not match clog2(PAT_W).
    function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] idx);
        logic [PAT_W-1:0] s;
        s = p >> idx;
        return s[0];
    endfunction

    always_comb begin
        len_ok = 1'b0;
        len_ok = (len != '0) && (len <= LEN_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            data    <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && len_ok) begin
                        pat_q   <= pattern;
                        len_q   <= len;
                        gap_q   <= gap;
                        rep_cnt <= reps;
                        bit_idx <= len - LEN_ONE;
                        data    <= bit_at(pattern, len - LEN_ONE);
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                        data  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - LEN_ONE;
                        data    <= bit_at(pat_q, bit_idx - LEN_ONE);
                    end else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - REP_ONE;
                        if (gap_q != '0) begin
                            // gap_cnt holds the gap cycles remaining after the current one
                            gap_cnt <= gap_q - GAP_ONE;
                            data    <= 1'b0;
                            valid   <= 1'b0;
                            state   <= GAP;
                        end else begin
                            bit_idx <= len_q - LEN_ONE;
                            data    <= bit_at(pat_q, len_q - LEN_ONE);
                        end
                    end else begin
                        state <= DONE;
                        data  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        data  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        bit_idx <= len_q - LEN_ONE;
                        data    <= bit_at(pat_q, len_q - LEN_ONE);
                        valid   <= 1'b1;
                        state   <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    data  <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator; outputs are compared as the packed
// vector {data, valid, busy, ready, done} one time unit after each rising edge.
module tb_serial_pattern_generator;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] pattern;
    logic [3:0] len, reps, gap;
    logic       data, valid, busy, ready, done;
    logic [4:0] obs;

    int tests = 0;
    int fails = 0;

    localparam logic [4:0] IDLE_V = 5'b00010;
    localparam logic [4:0] DONE_V = 5'b00001;
    localparam logic [4:0] GAP_V  = 5'b00100;
    localparam logic [4:0] ON1    = 5'b11100;
    localparam logic [4:0] ON0    = 5'b01100;

    serial_pattern_generator #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .reps(reps), .gap(gap),
        .data(data), .valid(valid), .busy(busy), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {data, valid, busy, ready, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] seq8 [8];
        logic [8:0] b2b;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = 8'h00; len = 4'd0; reps = 4'd0; gap = 4'd0;
        tick(); tick();
        chk("reset", IDLE_V);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", IDLE_V);

        // single pass 101
        pattern = 8'h05; len = 4'd3; reps = 4'd0; gap = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("single_b1", ON1);
        tick(); chk("single_b2", ON0);
        tick(); chk("single_b3", ON1);
        tick(); chk("single_done", DONE_V);
        tick(); chk("single_ready", IDLE_V);

        // back-to-back repeats
        reps = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        b2b = 9'b101101101;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk($sformatf("b2b_bit%0d", i), b2b[8-i] ? ON1 : ON0);
        end
        tick(); chk("b2b_done", DONE_V);
        tick(); chk("b2b_ready", IDLE_V);

        // gapped repeats
        reps = 4'd1; gap = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        seq8 = '{ON1, ON0, ON1, GAP_V, GAP_V, ON1, ON0, ON1};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("gap_cyc%0d", i + 1), seq8[i]);
        end
        tick(); chk("gap_done", DONE_V);
        tick(); chk("gap_ready", IDLE_V);

        // illegal lengths ignored
        pattern = 8'hFF; len = 4'd0; reps = 4'd0; gap = 4'd0; start = 1'b1;
        tick(); chk("len0_a", IDLE_V);
        tick(); chk("len0_b", IDLE_V);
        len = 4'd9;
        tick(); chk("len9", IDLE_V);
        start = 1'b0;

        // start during SEND and DONE is dropped
        pattern = 8'h05; len = 4'd3; start = 1'b1;
        tick();
        chk("midstart_b1", ON1);
        pattern = 8'hFF; len = 4'd8; reps = 4'd3;
        tick(); chk("midstart_b2", ON0);
        tick(); chk("midstart_b3", ON1);
        tick(); chk("midstart_done", DONE_V);
        tick(); chk("midstart_idle", IDLE_V);
        start = 1'b0;
        tick(); chk("midstart_no_second", IDLE_V);

        // abort on 2nd bit of len=8
        pattern = 8'hA6; len = 4'd8; reps = 4'd0; gap = 4'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("abort_b1", ON1);
        tick(); chk("abort_b2", ON0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort_idle", IDLE_V);
        tick(); chk("abort_no_done_a", IDLE_V);
        tick(); chk("abort_no_done_b", IDLE_V);
        pattern = 8'h05; len = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk("post_abort_b1", ON1);
        tick(); chk("post_abort_b2", ON0);
        tick(); chk("post_abort_b3", ON1);
        tick(); chk("post_abort_done", DONE_V);
        tick(); chk("post_abort_idle", IDLE_V);

        // start+abort together in IDLE, len=1 repeated
        pattern = 8'h01; len = 4'd1; reps = 4'd2; start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        chk("len1_c1", ON1);
        tick(); chk("len1_c2", ON1);
        tick(); chk("len1_c3", ON1);
        tick(); chk("len1_done", DONE_V);
        tick(); chk("len1_idle", IDLE_V);

        // abort during GAP
        pattern = 8'h05; len = 4'd3; reps = 4'd1; gap = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        chk("gabort_b1", ON1);
        tick(); chk("gabort_b2", ON0);
        tick(); chk("gabort_b3", ON1);
        tick(); chk("gabort_gap", GAP_V);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("gabort_idle", IDLE_V);
        tick(); chk("gabort_no_done", IDLE_V);

        // reset mid-GAP then replay
        pattern = 8'h06; len = 4'd3; reps = 4'd1; gap = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        chk("rgap_b1", ON1);
        tick(); chk("rgap_b2", ON1);
        tick(); chk("rgap_b3", ON0);
        tick(); chk("rgap_gap", GAP_V);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rgap_reset", IDLE_V);
        start = 1'b1;
        tick(); start = 1'b0;
        seq8 = '{ON1, ON1, ON0, GAP_V, GAP_V, ON1, ON1, ON0};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("replay_cyc%0d", i + 1), seq8[i]);
        end
        tick(); chk("replay_done", DONE_V);
        tick(); chk("replay_idle", IDLE_V);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
